imem_loader: RTL

Boot/run controller that sits directly upstream of the mips core.
- Accepts a byte stream on a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into the instruction memory write port.
- Releases the core's reset and counts run cycles until the core raises halt or a timeout expires.
- Replaces file preloading of instruction memory with a synthesizable load path.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_assembler.sv | 47 ++++
 rtl/imem_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared loader state encodings, default end-of-program marker and the byte shift helper.
package imem_loader_pkg;

  localparam logic [2:0] LDR_LOAD    = 3'd0;
  localparam logic [2:0] LDR_WRITE   = 3'd1;
  localparam logic [2:0] LDR_RUN     = 3'd2;
  localparam logic [2:0] LDR_DONE    = 3'd3;
  localparam logic [2:0] LDR_TIMEOUT = 3'd4;

  localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Big-endian assembly: the oldest byte ends up in bits [31:24].
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] data);
    return {word[23:0], data};
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid marks the accept of the fourth byte.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] word_d, word_q;
  logic [1:0]  cnt_d, cnt_q;

  // Next shift register and byte counter; clear discards any partial word.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = 32'h0000_0000;
      cnt_d  = 2'd0;
    end else if (accept) begin
      word_d = shift_in_byte(word_q, byte_in);
      cnt_d  = cnt_q + 2'd1;
    end else begin
      word_d = word_q;
      cnt_d  = cnt_q;
    end
  end

  // Assembly state flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= 32'h0000_0000;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_valid = accept && (cnt_q == 2'd3) && !clear;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot/run controller: streams a program into instruction memory, then runs the core until halt or timeout.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] END_WORD   = END_WORD_DEFAULT,
  parameter int unsigned MAX_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  input  logic                  cpu_halt,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           cycle_count,
  output logic                  done,
  output logic                  timeout
);

  localparam logic [31:0]           MAX_C    = 32'(MAX_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  logic [2:0]            state_d, state_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [ADDR_WIDTH:0]   wc_d, wc_q;
  logic [31:0]           cc_d, cc_q;
  logic                  rx_ready_d, rx_ready_q;
  logic                  cpu_reset_d, cpu_reset_q;
  logic                  imem_we_d, imem_we_q;
  logic                  done_d, done_q;
  logic                  timeout_d, timeout_q;

  logic        accept_s;
  logic        asm_clear_s;
  logic        word_valid_s;
  logic [31:0] asm_word_s;
  logic [31:0] cc_inc_s;

  assign accept_s = rx_valid && rx_ready_q;
  assign cc_inc_s = cc_q + 32'd1;

  imem_loader_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear_s),
    .accept     (accept_s),
    .byte_in    (rx_data),
    .word_valid (word_valid_s),
    .word       (asm_word_s)
  );

  // Loader FSM and counter next-state logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wc_d        = wc_q;
    cc_d        = cc_q;
    asm_clear_s = 1'b0;
    case (state_q)
      LDR_LOAD: begin
        if (word_valid_s) state_d = LDR_WRITE;
        else              state_d = LDR_LOAD;
      end
      LDR_WRITE: begin
        wc_d = wc_q + (ADDR_WIDTH+1)'(1'b1);
        if ((asm_word_s == END_WORD) || (addr_q == ADDR_MAX)) begin
          state_d = LDR_RUN;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1'b1);
          state_d = LDR_LOAD;
        end
      end
      LDR_RUN: begin
        // Halt takes priority over reaching the cycle limit on the same cycle.
        if (cpu_halt) begin
          state_d = LDR_DONE;
        end else if (cc_q >= MAX_C) begin
          state_d = LDR_TIMEOUT;
        end else begin
          cc_d = cc_inc_s;
          if (cc_inc_s >= MAX_C) state_d = LDR_TIMEOUT;
          else                   state_d = LDR_RUN;
        end
      end
      LDR_DONE, LDR_TIMEOUT: begin
        if (restart) begin
          state_d     = LDR_LOAD;
          addr_d      = {ADDR_WIDTH{1'b0}};
          wc_d        = {(ADDR_WIDTH+1){1'b0}};
          cc_d        = 32'd0;
          asm_clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = LDR_LOAD;
        addr_d      = {ADDR_WIDTH{1'b0}};
        wc_d        = {(ADDR_WIDTH+1){1'b0}};
        cc_d        = 32'd0;
        asm_clear_s = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they describe.
  always_comb begin
    rx_ready_d  = (state_d == LDR_LOAD);
    cpu_reset_d = (state_d == LDR_LOAD) || (state_d == LDR_WRITE);
    imem_we_d   = (state_d == LDR_WRITE);
    done_d      = (state_d == LDR_DONE);
    timeout_d   = (state_d == LDR_TIMEOUT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LDR_LOAD;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wc_q        <= {(ADDR_WIDTH+1){1'b0}};
      cc_q        <= 32'd0;
      rx_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      imem_we_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wc_q        <= wc_d;
      cc_q        <= cc_d;
      rx_ready_q  <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      imem_we_q   <= imem_we_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign cpu_reset   = cpu_reset_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = imem_we_q ? asm_word_s : 32'h0000_0000;
  assign word_count  = wc_q;
  assign cycle_count = cc_q;
  assign done        = done_q;
  assign timeout     = timeout_q;

endmodule
